// File: rtl/input_vc_arbiter_if.sv
// Handshake bundle between the input VC buffers/source, the output allocator and the arbiter.
interface input_vc_arbiter_if #(
    parameter int unsigned vc_num     = 3,
    parameter int unsigned prio_num   = 2,
    parameter int unsigned output_num = 8
);
    localparam int unsigned n  = vc_num * prio_num;
    localparam int unsigned vw = (n > 1) ? $clog2(n) : 1;

    logic [n-1:0]          i_has_packet;
    logic [output_num-1:0] dest_i [n];
    logic [vw-1:0]         output_vc_i [n];
    logic [n-1:0]          i_credit_avail;
    logic [output_num-1:0] o_req;
    logic [vw-1:0]         o_req_vc;
    logic                  i_grant;
    logic                  cts;
    logic [vw-1:0]         selected_vc;
    logic                  last;
    logic                  o_busy;

    // Arbiter side
    modport master (
        input  i_has_packet, dest_i, output_vc_i, i_credit_avail, i_grant, last,
        output o_req, o_req_vc, cts, selected_vc, o_busy
    );

    // Source / allocator side
    modport slave (
        output i_has_packet, dest_i, output_vc_i, i_credit_avail, i_grant, last,
        input  o_req, o_req_vc, cts, selected_vc, o_busy
    );
endinterface

// File: rtl/input_vc_arbiter.sv
// Input-port VC arbiter: picks one eligible VC (strict priority between levels,
// round-robin inside a level), requests its switch output, then grants the
// source clear-to-send until the packet tail.
module input_vc_arbiter #(
    parameter int unsigned vc_num     = 3,
    parameter int unsigned prio_num   = 2,
    parameter int unsigned output_num = 8
) (
    input  logic                clk,
    input  logic                reset,
    input_vc_arbiter_if.master  bus
);
    localparam int unsigned n  = vc_num * prio_num;
    localparam int unsigned vw = (n > 1) ? $clog2(n) : 1;
    localparam int unsigned lw = (vc_num > 1) ? $clog2(vc_num) : 1;
    localparam int unsigned pw = (prio_num > 1) ? $clog2(prio_num) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t                state;
    logic [output_num-1:0] req_q;
    logic [vw-1:0]         req_vc_q;
    logic [vw-1:0]         sel_q;
    logic                  cts_q;
    logic                  busy_q;
    logic [lw-1:0]         rr_ptr [prio_num];

    logic [n-1:0]          elig_c;
    logic                  win_valid_c;
    logic [vw-1:0]         win_c;
    logic [pw-1:0]         sel_level_c;
    logic [lw-1:0]         sel_local_c;

    // A VC is eligible with a pending packet, a one-hot destination and credit on its output VC
    always_comb begin
        elig_c = '0;
        for (int v = 0; v < int'(n); v++) begin
            elig_c[vw'(v)] = bus.i_has_packet[vw'(v)]
                           && $onehot(bus.dest_i[vw'(v)])
                           && bus.i_credit_avail[bus.output_vc_i[vw'(v)]];
        end
    end

    // Highest level with any eligible VC wins; inside it search from rr_ptr+1 with wrap
    always_comb begin
        win_valid_c = 1'b0;
        win_c       = '0;
        for (int p = int'(prio_num) - 1; p >= 0; p--) begin
            for (int k = 1; k <= int'(vc_num); k++) begin
                if (!win_valid_c &&
                    elig_c[vw'(p * int'(vc_num) + ((int'(rr_ptr[pw'(p)]) + k) % int'(vc_num)))]) begin
                    win_valid_c = 1'b1;
                    win_c       = vw'(p * int'(vc_num) + ((int'(rr_ptr[pw'(p)]) + k) % int'(vc_num)));
                end
            end
        end
    end

    // Level and in-level index of the selected VC, used for the pointer update
    always_comb begin
        sel_level_c = pw'(int'(sel_q) / int'(vc_num));
        sel_local_c = lw'(int'(sel_q) % int'(vc_num));
    end

    // Control FSM with registered outputs; pointers move only on a completed packet
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_q    <= '0;
            req_vc_q <= '0;
            sel_q    <= '0;
            cts_q    <= 1'b0;
            busy_q   <= 1'b0;
            for (int p = 0; p < int'(prio_num); p++) begin
                rr_ptr[pw'(p)] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid_c) begin
                        state    <= REQ;
                        busy_q   <= 1'b1;
                        sel_q    <= win_c;
                        req_q    <= bus.dest_i[win_c];
                        req_vc_q <= bus.output_vc_i[win_c];
                    end
                end
                REQ: begin
                    if (bus.i_grant) begin
                        state <= XFER;
                        req_q <= '0;
                        cts_q <= 1'b1;
                    end else if (!bus.i_has_packet[sel_q]) begin
                        state  <= IDLE;
                        req_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                XFER: begin
                    if (bus.last) begin
                        state               <= IDLE;
                        cts_q               <= 1'b0;
                        busy_q              <= 1'b0;
                        rr_ptr[sel_level_c] <= sel_local_c;
                    end
                end
                default: begin
                    state  <= IDLE;
                    req_q  <= '0;
                    cts_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req       = req_q;
    assign bus.o_req_vc    = req_vc_q;
    assign bus.selected_vc = sel_q;
    assign bus.cts         = cts_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_input_vc_arbiter.sv
// Scenario bench for input_vc_arbiter: expected selections are queued when
// packets are offered and checked as the arbiter raises each request.
module tb_input_vc_arbiter;
    localparam int unsigned vc_num     = 3;
    localparam int unsigned prio_num   = 2;
    localparam int unsigned output_num = 8;
    localparam int unsigned n          = vc_num * prio_num;
    localparam int unsigned vw         = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    input_vc_arbiter_if #(.vc_num(vc_num), .prio_num(prio_num), .output_num(output_num)) bus ();

    input_vc_arbiter #(.vc_num(vc_num), .prio_num(prio_num), .output_num(output_num)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                    vc;
        logic [output_num-1:0] dest;
        logic [vw-1:0]         ovc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        bus.i_has_packet   = '0;
        bus.i_credit_avail = '1;
        bus.i_grant        = 1'b0;
        bus.last           = 1'b0;
        for (int v = 0; v < int'(n); v++) begin
            bus.dest_i[v]      = output_num'(1) << v;
            bus.output_vc_i[v] = vw'(v);
        end
    endtask

    task automatic do_reset();
        set_defaults();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_vc(input int v);
        exp_t e;
        e.vc   = v;
        e.dest = bus.dest_i[v];
        e.ovc  = bus.output_vc_i[v];
        sb.push_back(e);
    endtask

    // Wait for a request, check it against the scoreboard, then grant and finish the packet
    task automatic serve_one(input bit clear);
        exp_t e;
        int   waited = 0;
        while (bus.o_req == '0 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (bus.o_req == '0) begin
            errors++;
            $display("FAIL serve_timeout: o_req=%h after %0d cycles, required a request", bus.o_req, waited);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: request vc=%0d seen, none expected", bus.selected_vc);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.selected_vc !== vw'(e.vc)) begin
            errors++;
            $display("FAIL sel_vc: got %0d required %0d", bus.selected_vc, e.vc);
        end
        checks++;
        if (bus.o_req !== e.dest || bus.o_req_vc !== e.ovc) begin
            errors++;
            $display("FAIL req: got o_req=%h vc=%0d required o_req=%h vc=%0d", bus.o_req, bus.o_req_vc, e.dest, e.ovc);
        end
        checks++;
        if (bus.cts !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL req_state: got cts=%b busy=%b required cts=0 busy=1", bus.cts, bus.o_busy);
        end
        bus.i_grant = 1'b1;
        step();
        bus.i_grant = 1'b0;
        checks++;
        if (bus.cts !== 1'b1 || bus.selected_vc !== vw'(e.vc) || bus.o_req !== '0) begin
            errors++;
            $display("FAIL xfer: got cts=%b sel=%0d o_req=%h required cts=1 sel=%0d o_req=0",
                     bus.cts, bus.selected_vc, bus.o_req, e.vc);
        end
        bus.last = 1'b1;
        if (clear) bus.i_has_packet[e.vc] = 1'b0;
        step();
        bus.last = 1'b0;
        checks++;
        if (bus.cts !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL tail: got cts=%b busy=%b required cts=0 busy=0", bus.cts, bus.o_busy);
        end
    endtask

    task automatic test_reset();
        set_defaults();
        bus.i_has_packet = '1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.o_req !== '0 || bus.cts !== 1'b0 || bus.selected_vc !== '0 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: cycle %0d o_req=%h cts=%b sel=%0d busy=%b required all 0",
                         c, bus.o_req, bus.cts, bus.selected_vc, bus.o_busy);
            end
        end
        reset = 1'b0;
        expect_vc(4);
        step();
        checks++;
        if (bus.o_req !== 8'h10) begin
            errors++;
            $display("FAIL reset_release_latency: o_req=%h required 10", bus.o_req);
        end
        serve_one(1'b1);
    endtask

    task automatic test_single_vc();
        do_reset();
        bus.dest_i[1]      = 8'h04;
        bus.output_vc_i[1] = 3'd1;
        bus.i_has_packet   = 6'b000010;
        expect_vc(1);
        step();
        checks++;
        if (bus.o_req !== 8'h04 || bus.o_req_vc !== 3'd1) begin
            errors++;
            $display("FAIL single_latency: o_req=%h vc=%0d required 04 vc=1", bus.o_req, bus.o_req_vc);
        end
        serve_one(1'b1);
    endtask

    task automatic test_priority();
        do_reset();
        bus.i_has_packet = 6'b010001;
        expect_vc(4);
        expect_vc(0);
        serve_one(1'b1);
        serve_one(1'b1);
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.i_has_packet = 6'b000001;
        expect_vc(0);
        serve_one(1'b0);
        bus.i_has_packet = 6'b000111;
        expect_vc(1);
        expect_vc(2);
        expect_vc(0);
        serve_one(1'b0);
        serve_one(1'b0);
        serve_one(1'b0);
    endtask

    task automatic test_ineligible();
        do_reset();
        bus.i_has_packet = 6'b001000;
        bus.dest_i[3]    = 8'h06;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.o_req !== '0 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL multihot_dest: o_req=%h busy=%b required 0", bus.o_req, bus.o_busy);
            end
        end
        bus.dest_i[3]      = 8'h02;
        bus.output_vc_i[3] = 3'd4;
        bus.i_credit_avail = 6'b101111;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.o_req !== '0 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL no_credit: o_req=%h busy=%b required 0", bus.o_req, bus.o_busy);
            end
        end
        bus.i_credit_avail = '1;
        expect_vc(3);
        step();
        checks++;
        if (bus.o_req !== 8'h02) begin
            errors++;
            $display("FAIL fixed_latency: o_req=%h required 02", bus.o_req);
        end
        serve_one(1'b1);
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.i_has_packet = 6'b000101;
        step();
        checks++;
        if (bus.selected_vc !== 3'd2 || bus.o_req !== 8'h04) begin
            errors++;
            $display("FAIL withdraw_pick: sel=%0d o_req=%h required sel=2 o_req=04", bus.selected_vc, bus.o_req);
        end
        bus.i_has_packet[2] = 1'b0;
        step();
        checks++;
        if (bus.o_req !== '0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_drop: o_req=%h busy=%b required 0", bus.o_req, bus.o_busy);
        end
        expect_vc(0);
        serve_one(1'b1);
        // Grant and withdraw together: grant takes precedence
        bus.i_has_packet = 6'b000100;
        step();
        checks++;
        if (bus.selected_vc !== 3'd2 || bus.o_req !== 8'h04) begin
            errors++;
            $display("FAIL gw_pick: sel=%0d o_req=%h required sel=2 o_req=04", bus.selected_vc, bus.o_req);
        end
        bus.i_grant         = 1'b1;
        bus.i_has_packet[2] = 1'b0;
        step();
        bus.i_grant = 1'b0;
        checks++;
        if (bus.cts !== 1'b1 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL grant_wins: cts=%b busy=%b required cts=1 busy=1", bus.cts, bus.o_busy);
        end
        bus.last = 1'b1;
        step();
        bus.last = 1'b0;
        checks++;
        if (bus.cts !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL gw_tail: cts=%b busy=%b required 0", bus.cts, bus.o_busy);
        end
    endtask

    task automatic test_reset_xfer();
        do_reset();
        bus.i_has_packet = 6'b000010;
        step();
        bus.i_grant = 1'b1;
        step();
        bus.i_grant = 1'b0;
        checks++;
        if (bus.cts !== 1'b1) begin
            errors++;
            $display("FAIL rx_xfer: cts=%b required 1", bus.cts);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.i_has_packet = '0;
        checks++;
        if (bus.cts !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_req !== '0 || bus.selected_vc !== '0) begin
            errors++;
            $display("FAIL rx_abort: cts=%b busy=%b o_req=%h sel=%0d required all 0",
                     bus.cts, bus.o_busy, bus.o_req, bus.selected_vc);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        bus.i_grant = 1'b1;
        bus.last    = 1'b1;
        step();
        step();
        bus.i_grant = 1'b0;
        bus.last    = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.cts !== 1'b0 || bus.o_req !== '0) begin
            errors++;
            $display("FAIL idle_ignore: busy=%b cts=%b o_req=%h required 0", bus.o_busy, bus.cts, bus.o_req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_defaults();
        test_reset();
        test_single_vc();
        test_priority();
        test_round_robin();
        test_ineligible();
        test_withdraw();
        test_reset_xfer();
        test_ignored();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected selections never seen, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_vc_arbiter.md
Name: input_vc_arbiter

Overview:
- Consumer-side partner of the per-VC packet source model. Takes per-VC has_packet, dest and output_vc requests, selects one VC and requests its switch output.
- After the output allocator grants, it asserts cts/selected_vc toward the source and holds the transfer until the source signals last.
- Sits between the input VC buffers and the output allocator in the switch input port.

Parameters:
- vc_num, 3, virtual channels per priority level
- prio_num, 2, priority levels; total VCs N = vc_num*prio_num
- output_num, 8, switch outputs; dest is one-hot of this width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_has_packet  in  N  per-VC packet-pending flags
- dest_i  in  output_num x N (unpacked)  per-VC one-hot destination
- output_vc_i  in  clog2(N) x N (unpacked)  per-VC requested output VC
- i_credit_avail  in  N  bit k=1 means output VC k has downstream space
- o_req  out  output_num  one-hot output request (copy of latched dest)
- o_req_vc  out  clog2(N)  output VC of the pending request
- i_grant  in  1  output allocator grant for o_req
- cts  out  1  clear-to-send to source for o_selected_vc
- selected_vc  out  clog2(N)  VC currently selected
- last  in  1  tail of the packet on selected_vc
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (sync, active-high): state=IDLE; o_req=0, o_req_vc=0, cts=0, selected_vc=0, o_busy=0; all round-robin pointers=0. Reset mid-transfer aborts to IDLE with no pointer update.
- Eligibility of VC v: i_has_packet[v]=1 AND dest_i[v] has exactly one bit set AND i_credit_avail[output_vc_i[v]]=1. Zero or multi-hot dest makes VC ineligible; it is never selected.
- Priority level of v = v / vc_num; higher level wins absolutely (VCs N-vc_num..N-1 are highest).
- Within a level: round-robin. Search starts at rr_ptr[level]+1 and wraps modulo vc_num inside the level.
- FSM states IDLE, REQ, XFER:
  - IDLE: if any VC is eligible, latch winner v into selected_vc, dest_i[v] into o_req, output_vc_i[v] into o_req_vc; go to REQ next cycle. Latency from has_packet high to o_req valid is 1 cycle.
  - REQ: o_req held stable.
    - i_grant=1: go to XFER next cycle.
    - i_has_packet[selected_vc] drops (withdraw) and no grant: o_req=0, go to IDLE, no pointer update.
    - i_grant and withdraw in the same cycle: grant wins.
  - XFER: cts=1, selected_vc stable, o_req=0. On last=1: cts drops the next cycle, state=IDLE, and rr_ptr[level(selected_vc)]=selected_vc. The same VC may be re-selected in the following IDLE cycle only if it is the sole eligible VC in its level.
- i_grant outside REQ and last outside XFER are ignored.
- Credit is checked only at selection; credit loss during REQ/XFER does not abort.
- Minimum cycle per packet is IDLE->REQ->XFER->IDLE, i.e. 3 cycles when grant and last arrive immediately.
- o_busy = (state != IDLE).

Test Plan:
- Reset held 3 cycles with i_has_packet=6'b111111 -> o_req=0, cts=0, selected_vc=0 throughout. After release: o_req valid on cycle 1.
- Only VC1 pending, dest=8'h04, output_vc=1, credit all 1 -> o_req=8'h04, o_req_vc=1 after 1 cycle. Grant -> cts=1, selected_vc=1 next cycle. last -> cts=0, IDLE.
- VC0 and VC4 both pending -> VC4 (high priority) selected first. After VC4's last, VC0 is selected.
- VC0, VC1, VC2 pending continuously, grant/last immediate -> selection order 0,1,2,0 (pointer wraps within level 0).
- VC3 pending with dest=8'h06 (multi-hot), or with credit_avail[output_vc]=0 -> never selected, o_req stays 0. Fix dest to 8'h02 and raise credit -> selected next cycle.
- VC2 in REQ, has_packet[2] drops before grant -> o_req=0 next cycle, returns to IDLE, VC0 next in RR order. Separately, reset during XFER -> cts=0 next cycle.
